// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared definitions for the set-associative data cache.
//               Ins_Type encodings, miss FSM state encoding, width helper and
//               the store byte-enable decode.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Ins_Type encodings
  localparam logic [1:0] INS_WORD = 2'd0;
  localparam logic [1:0] INS_HALF = 2'd1;
  localparam logic [1:0] INS_BYTE = 2'd2;
  localparam logic [1:0] INS_RSVD = 2'd3;

  // Miss FSM states
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  // log2 that never returns 0, so a 1-way pointer still has a legal width
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte lanes written by a store; reserved type writes nothing
  function automatic logic [3:0] byte_enable(input logic [1:0] ins,
                                             input logic [1:0] a);
    case (ins)
      INS_WORD: return 4'b1111;
      INS_HALF: return a[1] ? 4'b1100 : 4'b0011;
      INS_BYTE: return 4'b0001 << a;
      default:  return 4'b0000;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_way.sv
`default_nettype none
// ============================================================================
// Module      : cache_way
// Description : One way of the cache: valid/dirty bits, tag and data arrays.
//               Combinational read by idx; byte-enabled word write from the
//               CPU (sets dirty) and full-block fill (sets valid, clears dirty).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               idx               - set index for read and write
//               rd_valid/dirty/tag/block - contents of the indexed line
//               cpu_we/word/be/wdata     - store into one word of the line
//               fill_we/tag/data         - install a new block
// Revision    : 1.0 - initial release
// ============================================================================
module cache_way
  import cache_pkg::*;
#(
  parameter int SETS            = 256,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int TAG_W           = 20
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [$clog2(SETS)-1:0]           idx,
  output logic                              rd_valid,
  output logic                              rd_dirty,
  output logic [TAG_W-1:0]                  rd_tag,
  output logic [32*WORDS_PER_BLOCK-1:0]     rd_block,
  input  logic                              cpu_we,
  input  logic [$clog2(WORDS_PER_BLOCK)-1:0] cpu_word,
  input  logic [3:0]                        cpu_be,
  input  logic [31:0]                       cpu_wdata,
  input  logic                              fill_we,
  input  logic [TAG_W-1:0]                  fill_tag,
  input  logic [32*WORDS_PER_BLOCK-1:0]     fill_data
);
  localparam int BLK_W = 32 * WORDS_PER_BLOCK;

  logic [SETS-1:0]  valid_q;
  logic [SETS-1:0]  dirty_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [BLK_W-1:0] data_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_block = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (cpu_we && (cpu_be != 4'b0000)) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: valid gates every use
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (cpu_we) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_be[b])
          data_q[idx][32*int'(cpu_word) + 8*b +: 8] <= cpu_wdata[8*b +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : cache_assoc
// Description : N-way set-associative write-back, write-allocate data cache
//               with 0-cycle hits and an IDLE/WRITEBACK/ALLOCATE miss FSM.
//               Define CACHE_STATS_EN to add saturating Hit/Miss/Wb counters.
// Ports       : clk, rst                      - clock, sync active-high reset
//               Req_CPU/Wr_CPU/A_CPU/DI_CPU/Ins_Type -> Rdy_CPU/DO_CPU (CPU)
//               Req_Low/Wr_Low/A_Low/DO_Low <- Rdy_Low/DI_Low (memory)
//               Hit_Cnt/Miss_Cnt/Wb_Cnt       - only with CACHE_STATS_EN
// Revision    : 1.0 - initial release
// ============================================================================
module cache_assoc
  import cache_pkg::*;
#(
  parameter int WAYS            = 2,
  parameter int SETS            = 256,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  Req_CPU,
  input  logic                                  Wr_CPU,
  input  logic [31:0]                           A_CPU,
  input  logic [31:0]                           DI_CPU,
  input  logic [1:0]                            Ins_Type,
  output logic                                  Rdy_CPU,
  output logic [31:0]                           DO_CPU,
  output logic                                  Req_Low,
  output logic                                  Wr_Low,
  output logic [31-$clog2(WORDS_PER_BLOCK)-2:0] A_Low,
  output logic [32*WORDS_PER_BLOCK-1:0]         DO_Low,
  input  logic                                  Rdy_Low,
  input  logic [32*WORDS_PER_BLOCK-1:0]         DI_Low
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]                           Hit_Cnt,
  output logic [31:0]                           Miss_Cnt,
  output logic [31:0]                           Wb_Cnt
`endif
);
  localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int OFF_W  = WOFF_W + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - IDX_W - OFF_W;
  localparam int BLK_W  = 32 * WORDS_PER_BLOCK;
  localparam int ALOW_W = 32 - OFF_W;
  localparam int WAY_W  = clog2_min1(WAYS);

  state_t            state;
  logic [WAY_W-1:0]  victim_q;
  logic [ALOW_W-1:0] miss_addr;   // block address of the miss in flight

  logic [IDX_W-1:0]  cpu_idx;
  logic [TAG_W-1:0]  cpu_tag;
  logic [WOFF_W-1:0] word_off;
  logic [IDX_W-1:0]  way_idx;
  logic [3:0]        be;

  logic [WAYS-1:0]   way_valid;
  logic [WAYS-1:0]   way_dirty;
  logic [TAG_W-1:0]  way_tag [WAYS];
  logic [BLK_W-1:0]  way_blk [WAYS];

  logic [WAYS-1:0]   hit_vec;
  logic [BLK_W-1:0]  hit_blk;
  logic              hit;
  logic [WAY_W-1:0]  rr_cur;
  logic [WAY_W-1:0]  victim;
  logic              found;
  logic              store_hit;
  logic              fill_done;

  assign cpu_idx  = A_CPU[OFF_W +: IDX_W];
  assign cpu_tag  = A_CPU[31 -: TAG_W];
  assign word_off = A_CPU[2 +: WOFF_W];
  assign be       = byte_enable(Ins_Type, A_CPU[1:0]);

  // During a miss the arrays follow the latched address, so a CPU that
  // drops its request cannot redirect the fill to another set.
  assign way_idx  = (state == ST_IDLE) ? cpu_idx : miss_addr[IDX_W-1:0];

  always_comb begin
    hit_vec = '0;
    hit_blk = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == cpu_tag)) begin
        hit_vec[w] = 1'b1;
        hit_blk    = hit_blk | way_blk[w];
      end
    end
  end

  assign hit       = |hit_vec;
  assign DO_CPU    = hit_blk[32*int'(word_off) +: 32];
  assign Rdy_CPU   = (state == ST_IDLE) && Req_CPU && hit && !rst;
  assign store_hit = Rdy_CPU && Wr_CPU;
  assign fill_done = (state == ST_ALLOCATE) && Req_Low && Rdy_Low;

  // Victim: lowest invalid way, otherwise the set's round-robin pointer
  always_comb begin
    victim = rr_cur;
    found  = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!way_valid[w] && !found) begin
        victim = WAY_W'(w);
        found  = 1'b1;
      end
    end
  end

  if (WAYS > 1) begin : g_rr
    logic [WAY_W-1:0] rr_q [SETS];
    assign rr_cur = rr_q[cpu_idx];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (fill_done) begin
        rr_q[miss_addr[IDX_W-1:0]] <= rr_q[miss_addr[IDX_W-1:0]] + 1'b1;
      end
    end
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    cache_way #(
      .SETS            (SETS),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .TAG_W           (TAG_W)
    ) u_way (
      .clk       (clk),
      .rst       (rst),
      .idx       (way_idx),
      .rd_valid  (way_valid[w]),
      .rd_dirty  (way_dirty[w]),
      .rd_tag    (way_tag[w]),
      .rd_block  (way_blk[w]),
      .cpu_we    (store_hit && hit_vec[w]),
      .cpu_word  (word_off),
      .cpu_be    (be),
      .cpu_wdata (DI_CPU),
      .fill_we   (fill_done && !rst && (victim_q == WAY_W'(w))),
      .fill_tag  (miss_addr[ALOW_W-1 -: TAG_W]),
      .fill_data (DI_Low)
    );
  end

  // Miss FSM; all memory-side outputs are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      Req_Low   <= 1'b0;
      Wr_Low    <= 1'b0;
      A_Low     <= '0;
      DO_Low    <= '0;
      victim_q  <= '0;
      miss_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (Req_CPU && !hit) begin
            victim_q  <= victim;
            miss_addr <= A_CPU[31:OFF_W];
            Req_Low   <= 1'b1;
            if (way_dirty[victim]) begin
              state  <= ST_WRITEBACK;
              Wr_Low <= 1'b1;
              A_Low  <= {way_tag[victim], cpu_idx};
              DO_Low <= way_blk[victim];
            end else begin
              state  <= ST_ALLOCATE;
              Wr_Low <= 1'b0;
              A_Low  <= A_CPU[31:OFF_W];
            end
          end
        end
        ST_WRITEBACK: begin
          if (Rdy_Low) begin
            // One idle cycle on Req_Low separates writeback from fill
            state   <= ST_ALLOCATE;
            Req_Low <= 1'b0;
            Wr_Low  <= 1'b0;
            A_Low   <= miss_addr;
          end
        end
        ST_ALLOCATE: begin
          if (!Req_Low) begin
            Req_Low <= 1'b1;
          end else if (Rdy_Low) begin
            Req_Low <= 1'b0;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic after_fill;   // the lookup that follows a fill is not a first-lookup hit

  always_ff @(posedge clk) begin
    if (rst) begin
      after_fill <= 1'b0;
      Hit_Cnt    <= '0;
      Miss_Cnt   <= '0;
      Wb_Cnt     <= '0;
    end else begin
      after_fill <= fill_done;
      if (Rdy_CPU && !after_fill && (Hit_Cnt != '1))
        Hit_Cnt <= Hit_Cnt + 1'b1;
      if ((state == ST_IDLE) && Req_CPU && !hit && (Miss_Cnt != '1))
        Miss_Cnt <= Miss_Cnt + 1'b1;
      if ((state == ST_WRITEBACK) && Rdy_Low && (Wb_Cnt != '1))
        Wb_Cnt <= Wb_Cnt + 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_assoc.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_assoc
// Description : Self-checking bench for cache_assoc (2 ways, 256 sets,
//               4 words/block). Directed scenarios followed by random
//               accesses, checked against an array-based cache/memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_assoc;
  localparam int WAYS = 2;
  localparam int SETS = 256;
  localparam int WPB  = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         Req_CPU, Wr_CPU, Rdy_CPU;
  logic [31:0]  A_CPU, DI_CPU, DO_CPU;
  logic [1:0]   Ins_Type;
  logic         Req_Low, Wr_Low, Rdy_Low;
  logic [27:0]  A_Low;
  logic [127:0] DO_Low, DI_Low;
`ifdef CACHE_STATS_EN
  logic [31:0]  Hit_Cnt, Miss_Cnt, Wb_Cnt;
`endif

  always #5 clk = ~clk;

  cache_assoc #(.WAYS(WAYS), .SETS(SETS), .WORDS_PER_BLOCK(WPB)) dut (
    .clk      (clk),
    .rst      (rst),
    .Req_CPU  (Req_CPU),
    .Wr_CPU   (Wr_CPU),
    .A_CPU    (A_CPU),
    .DI_CPU   (DI_CPU),
    .Ins_Type (Ins_Type),
    .Rdy_CPU  (Rdy_CPU),
    .DO_CPU   (DO_CPU),
    .Req_Low  (Req_Low),
    .Wr_Low   (Wr_Low),
    .A_Low    (A_Low),
    .DO_Low   (DO_Low),
    .Rdy_Low  (Rdy_Low),
    .DI_Low   (DI_Low)
`ifdef CACHE_STATS_EN
    ,
    .Hit_Cnt  (Hit_Cnt),
    .Miss_Cnt (Miss_Cnt),
    .Wb_Cnt   (Wb_Cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: per-way line state, per-set replacement pointer, memory
  bit          m_valid [WAYS][SETS];
  bit          m_dirty [WAYS][SETS];
  logic [19:0] m_tag   [WAYS][SETS];
  logic [31:0] m_data  [WAYS][SETS][WPB];
  int          m_rr    [SETS];
  logic [127:0] mem [logic [27:0]];
  int s_hit, s_miss, s_wb;

  function automatic logic [127:0] mem_rd(input logic [27:0] a);
    logic [127:0] b;
    if (mem.exists(a)) return mem[a];
    for (int i = 0; i < WPB; i++)
      b[i*32 +: 32] = ({a, 4'(i)} * 32'h9E3779B1) ^ 32'h13579BDF;
    return b;
  endfunction

  function automatic logic [127:0] line_of(input int w, input int s);
    logic [127:0] b;
    for (int i = 0; i < WPB; i++) b[i*32 +: 32] = m_data[w][s][i];
    return b;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < SETS; s++) m_rr[s] = 0;
    s_hit = 0; s_miss = 0; s_wb = 0;
  endtask

  // One CPU access, entered and left just after a falling edge.
  // Acts as the memory too, answering each request after 'lat' extra cycles.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] ins, input int lat);
    int s, wo, hw, vic, ntx, txc;
    logic [19:0] tg;
    bit miss, wb, got, just_done, stable, held_w;
    logic [27:0] wb_a, held_a;
    logic [127:0] wb_blk, held_d, fill_blk;
    logic [31:0] exp_rd;
    logic [3:0] bmask;
    s = int'(addr[11:4]); tg = addr[31:12]; wo = int'(addr[3:2]);
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_valid[w][s] && m_tag[w][s] == tg) hw = w;
    miss = (hw < 0); wb = 1'b0; wb_a = '0; wb_blk = '0;
    if (miss) begin
      vic = m_rr[s];
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][s]) vic = w;
      wb = m_dirty[vic][s];
      wb_a = {m_tag[vic][s], 8'(s)};
      wb_blk = line_of(vic, s);
      if (wb) begin mem[wb_a] = wb_blk; s_wb++; end
      fill_blk = mem_rd(addr[31:4]);
      m_valid[vic][s] = 1'b1; m_dirty[vic][s] = 1'b0; m_tag[vic][s] = tg;
      for (int i = 0; i < WPB; i++) m_data[vic][s][i] = fill_blk[i*32 +: 32];
      m_rr[s] = (m_rr[s] + 1) % WAYS;
      hw = vic; s_miss++;
    end else s_hit++;
    exp_rd = m_data[hw][s][wo];
    if (wr) begin
      case (ins)
        2'd0:    bmask = 4'hF;
        2'd1:    bmask = addr[1] ? 4'hC : 4'h3;
        2'd2:    bmask = 4'(1 << addr[1:0]);
        default: bmask = 4'h0;
      endcase
      for (int b = 0; b < 4; b++) if (bmask[b]) m_data[hw][s][wo][b*8 +: 8] = wd[b*8 +: 8];
      if (bmask != 0) m_dirty[hw][s] = 1'b1;
    end

    Req_CPU = 1'b1; Wr_CPU = wr; A_CPU = addr; DI_CPU = wd; Ins_Type = ins;
    ntx = 0; txc = 0; got = 0; just_done = 0; stable = 1; held_w = 0; held_a = '0; held_d = '0;
    for (int cyc = 0; cyc < 100 && !got; cyc++) begin
      #1;
      if (just_done) chk("req_low_drop", Req_Low, 1'b0);
      if (Rdy_CPU) begin
        got = 1;
        chk("do_cpu", DO_CPU, exp_rd);
        if (miss) chk("hit_cycle_after_fill", just_done, 1'b1);
      end else if (Req_Low) begin
        if (txc == 0) begin
          held_a = A_Low; held_w = Wr_Low; held_d = DO_Low;
          if (ntx == 0 && wb) begin
            chk("wb_wr_low", Wr_Low, 1'b1);
            chk("wb_a_low", A_Low, wb_a);
            chk("wb_do_low", DO_Low, wb_blk);
          end else begin
            chk("fill_wr_low", Wr_Low, 1'b0);
            chk("fill_a_low", A_Low, addr[31:4]);
          end
        end else if (A_Low !== held_a || Wr_Low !== held_w || DO_Low !== held_d) begin
          stable = 0;
        end
        if (txc == lat) begin
          Rdy_Low = 1'b1;
          DI_Low = held_w ? 128'h0 : mem_rd(held_a);
        end
        txc++;
      end
      @(negedge clk);
      just_done = 0;
      if (Rdy_Low) begin
        Rdy_Low = 1'b0; ntx++; txc = 0; just_done = 1;
      end
    end
    chk("completed", got, 1'b1);
    chk("mem_txns", ntx, miss ? (wb ? 2 : 1) : 0);
    if (miss) chk("mem_outputs_stable", stable, 1'b1);
    Req_CPU = 1'b0; Wr_CPU = 1'b0;
  endtask

  initial begin
    bit seen;
    logic [31:0] a, d;
    rst = 1'b1; Req_CPU = 0; Wr_CPU = 0; A_CPU = 0; DI_CPU = 0; Ins_Type = 0;
    Rdy_Low = 0; DI_Low = 0;
    model_reset();
    mem[28'h0000100] = {32'h44444444, 32'h33333333, 32'h22222222, 32'hAABBCCDD};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_rdy_cpu", Rdy_CPU, 1'b0);
    chk("reset_req_low", Req_Low, 1'b0);
    chk("reset_wr_low", Wr_Low, 1'b0);
    chk("reset_a_low", A_Low, 28'h0);
    chk("reset_do_low", DO_Low, 128'h0);

    // Clean miss and fill, then stores of each width and a reload
    access(0, 32'h00001000, 32'h0, 2'd0, 0);
    access(1, 32'h00001002, 32'h00EE0000, 2'd2, 0);
    access(0, 32'h00001000, 32'h0, 2'd0, 0);
    access(1, 32'h00001000, 32'h12345678, 2'd1, 0);
    access(1, 32'h00001000, 32'hFFFFFFFF, 2'd3, 0);
    access(0, 32'h00001000, 32'h0, 2'd0, 0);
    // Conflict misses: fill way1, then evict dirty way0 with a slow memory
    access(0, 32'h00002000, 32'h0, 2'd0, 1);
    access(0, 32'h00003000, 32'h0, 2'd0, 6);
    access(0, 32'h00005040, 32'h0, 2'd0, 6);

    // Rdy_Low outside a miss must be ignored
    Rdy_Low = 1'b1;
    @(negedge clk);
    Rdy_Low = 1'b0;
    #1;
    chk("idle_rdy_low_ignored", Req_Low, 1'b0);

    // Dirty 0x2000, then reset in the middle of its writeback
    access(1, 32'h00002004, 32'hCAFEF00D, 2'd0, 0);
    Req_CPU = 1'b1; Wr_CPU = 1'b0; A_CPU = 32'h00004000; Ins_Type = 2'd0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #1;
      if (Req_Low && Wr_Low) seen = 1;
    end
    chk("wb_before_reset", seen, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; Req_CPU = 1'b0;
    #1;
    chk("reset_abort_req_low", Req_Low, 1'b0);
    model_reset();
    access(0, 32'h00002000, 32'h0, 2'd0, 2);

    // Random traffic over a few sets and conflicting tags
    for (int n = 0; n < 200; n++) begin
      a = {20'($urandom_range(0, 4) * 32'h111 + 32'h7), 8'($urandom_range(0, 3)),
           4'($urandom_range(0, 15))};
      d = $urandom;
      access(1'($urandom_range(0, 1)), a, d, 2'($urandom_range(0, 3)), $urandom_range(0, 3));
    end

`ifdef CACHE_STATS_EN
    chk("hit_cnt", Hit_Cnt, s_hit);
    chk("miss_cnt", Miss_Cnt, s_miss);
    chk("wb_cnt", Wb_Cnt, s_wb);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
